mem_access_unit: RTL
====================

# mem_access_unit

Load/store front-end between the pipeline's MEM stage and the word-only data memory. It accepts one request at a time and issues aligned word reads and writes. Sub-word stores (sb/sh) become read-modify-write sequences, because the memory always writes full 32-bit words. Sub-word loads (lb/lbu/lh/lhu) get lane extraction plus sign or zero extension.

## Interface
Parameters:
- ADDR_W, 32, request/memory address width.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high exactly when state is IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified for sub-word stores.
- resp_valid  out  1  one-cycle completion pulse for every accepted request.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request; valid with resp_valid.
- mem_addr  out  ADDR_W  to data memory addr; always {latched_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  to data memory writeData.
- mem_write  out  1  to data memory MemWrite.
- mem_read  out  1  to data memory MemRead.
- mem_rdata  in  32  from data memory readData; valid the cycle after the edge that sampled the read.

## Operation
- Byte lanes are little-endian: offset 0 is bits [7:0]; a half at offset 2 is bits [31:16].
- The request is registered when req_valid && req_ready at a clock edge. That edge is A.
- mem_addr comes from a register and holds its value through every state, including IDLE. The memory's bank select samples the address every edge, so the address must stay stable during the data-return cycle.
- States:
  - IDLE
  - ISSUE: drive the word read, or the full-word write.
  - RDATA: mem_rdata valid; extract the load lane or merge the store lane.
  - WRITE: drive the merged word.
- Transitions:
  - IDLE, accept: if misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11), go to IDLE and pulse resp_err. Otherwise go to ISSUE.
  - ISSUE, word store: assert mem_write with mem_wdata=req_wdata, then go to IDLE with a response.
  - ISSUE, any load or sub-word store: assert mem_read, then go to RDATA.
  - RDATA, load: register the extracted, extended value in resp_rdata, then go to IDLE with a response.
  - RDATA, sub-word store: register the merged word (lane replaced, other bytes from mem_rdata), then go to WRITE.
  - WRITE: assert mem_write with the merged word, then go to IDLE with a response.
- mem_write and mem_read decode combinationally from the state. Both are 0 in IDLE and RDATA.
- resp_valid, resp_rdata and resp_err are registered and held for exactly one cycle. They return to 0 on the following edge unless a new response is produced.

## Timing
- Edges after A to the cycle in which resp_valid is high:
  - Misaligned: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- Back-to-back: req_ready is high in the cycle resp_valid is high, so a new request may be accepted at that cycle's edge.
- req_valid while req_ready=0 is ignored. The pipeline holds the request and stalls.
- Reset values, applied immediately and asynchronously:
  - state = IDLE.
  - resp_valid, resp_err, resp_rdata = 0.
  - Address register = 0, so mem_addr = 0.
  - mem_wdata = 0; mem_write = mem_read = 0.
- Reset in ISSUE or WRITE deasserts mem_write/mem_read before the next edge, so no write happens. The in-flight request is dropped with no response.

## Test plan
- Word store then load, addr 0x0000_4008: store data 0xDEADBEEF. Expect mem_write for 1 cycle and resp_valid 2 cycles after A. The load returns 0xDEADBEEF 3 cycles after its A, with mem_addr=0x4008 held through RDATA.
- Sign and zero extension on word 0x80FF7F01 at 0x100:
  - lb 0x101 → 0x0000007F.
  - lb 0x103 → 0xFFFFFF80.
  - lbu 0x102 → 0x000000FF.
  - lh 0x102 → 0xFFFF80FF.
  - lhu 0x100 → 0x00007F01.
- Read-modify-write, word 0x11223344 at 0x200:
  - sb 0xAA to 0x201 leaves 0x1122AA44, with sequence read, merge, write and resp_valid 4 cycles after A.
  - sh 0xBEEF to 0x202 then leaves 0xBEEFAA44.
- Misaligned and illegal: lh 0x101, sw 0x102 and size 11 each give resp_err=1 and resp_rdata=0 one cycle after A. mem_read and mem_write never assert and memory is unchanged.
- Back-to-back plus stall: hold req_valid high through 3 loads. req_ready is low outside IDLE, each load is accepted in its response cycle, and exactly 3 resp_valid pulses occur.
- Reset during WRITE of sb 0x55 to 0x300 (old word 0x01020304): memory still reads 0x01020304 afterwards, resp_valid never pulses, and all outputs are 0 while rst is high.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-only memory: sub-word stores become read-merge-write, sub-word loads are lane-extracted and extended.
// Response 1/2/3/4 edges after accept (error/sw/load/sb-sh); one request in flight, req_ready only in IDLE.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;

    logic              misaligned;
    logic              word_store;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign word_store = we_q && (size_q == 2'b10);
    assign req_ready  = (state == IDLE);
    assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write  = (state == WRITE) || ((state == ISSUE) && word_store);
    assign mem_read   = (state == ISSUE) && !word_store;

    assign ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_data = mem_rdata;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_data = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Store data was parked in mem_wdata at accept; its low lane is spliced into the read word.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = mem_wdata[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = mem_wdata[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        mem_wdata <= req_wdata;
                        if (misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (word_store) begin
                        resp_valid <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        state <= RDATA;
                    end
                end
                RDATA: begin
                    if (we_q) begin
                        mem_wdata <= merged;
                        state     <= WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                        state      <= IDLE;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
